// File: rtl/acc_exec_stage.sv
// acc_exec_stage: accumulator execute stage with ALU, branches, interrupt entry/return and an optional
// shift-add multiplier. Define ACC_EXEC_MUL_EN to build the multi-cycle MUL (opcode 13); otherwise opcode 13 is a NOP.
module acc_exec_stage #(
  parameter int DATA_W = 8,
  parameter int PC_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        StageRegInstr_out,
  input  logic [2:0]        StageRegAddrMode_out,
  input  logic [DATA_W-1:0] StageRegData_out,
  input  logic [PC_W-1:0]   StageRegPCtr_out,
  input  logic              irq,
  input  logic [PC_W-1:0]   InteruptAdrReg,
  output logic [DATA_W-1:0] ACCout,
  output logic              coutRegout,
  output logic              zeroRegout,
  output logic              overflowRegout,
  output logic [PC_W-1:0]   NextPctr,
  output logic              StageComplete
);

  localparam logic [4:0] OP_LDA = 5'd1;
  localparam logic [4:0] OP_ADD = 5'd2;
  localparam logic [4:0] OP_SUB = 5'd3;
  localparam logic [4:0] OP_AND = 5'd4;
  localparam logic [4:0] OP_OR  = 5'd5;
  localparam logic [4:0] OP_XOR = 5'd6;
  localparam logic [4:0] OP_NOT = 5'd7;
  localparam logic [4:0] OP_SHL = 5'd8;
  localparam logic [4:0] OP_SHR = 5'd9;
  localparam logic [4:0] OP_JMP = 5'd10;
  localparam logic [4:0] OP_JZ  = 5'd11;
  localparam logic [4:0] OP_JC  = 5'd12;
  localparam logic [4:0] OP_RTI = 5'd14;

  function automatic logic add_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] s);
    return ((a < 0) == (b < 0)) && ((s < 0) != (a < 0));
  endfunction

  function automatic logic sub_ovf(input logic signed [DATA_W-1:0] a,
                                   input logic signed [DATA_W-1:0] b,
                                   input logic signed [DATA_W-1:0] d);
    return ((a < 0) != (b < 0)) && ((d < 0) != (a < 0));
  endfunction

  logic              w_accept;
  logic              w_done;
  logic              w_mul_done;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W:0]   w_diff;
  logic [DATA_W-1:0] w_alu_acc;
  logic              w_alu_c;
  logic              w_alu_v;
  logic              w_alu_wr;
  logic              w_br_op;
  logic              w_br_cond;
  logic              w_is_rti;
  logic              w_is_mul;
  logic [PC_W-1:0]   w_pc_inc;
  logic signed [PC_W-1:0] w_off_sext;
  logic [PC_W-1:0]   w_tgt_abs;
  logic [PC_W-1:0]   w_tgt_rel;
  logic [PC_W-1:0]   w_pc_seq;
  logic              w_cmp;
  logic              w_wr;
  logic [PC_W-1:0]   w_cmp_npc;
  logic [DATA_W-1:0] w_res_acc;
  logic              w_res_c;
  logic              w_res_v;
  logic              w_take_irq;
  logic [PC_W-1:0]   r_epc;
  logic              r_ie;
  logic              r_pend;

  assign w_accept = in_valid & in_ready;
  assign w_done   = w_accept & ~w_is_mul;

  assign w_sum  = {1'b0, ACCout} + {1'b0, StageRegData_out};
  assign w_diff = {1'b0, ACCout} - {1'b0, StageRegData_out};

  always_comb begin
    w_alu_acc = ACCout;
    w_alu_c   = coutRegout;
    w_alu_v   = overflowRegout;
    w_alu_wr  = 1'b0;
    w_br_op   = 1'b0;
    w_br_cond = 1'b0;
    w_is_rti  = 1'b0;
    w_is_mul  = 1'b0;
    case (StageRegInstr_out)
      OP_LDA: begin
        w_alu_acc = StageRegData_out; w_alu_c = 1'b0; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_ADD: begin
        w_alu_acc = w_sum[DATA_W-1:0];
        w_alu_c   = w_sum[DATA_W];
        w_alu_v   = add_ovf(ACCout, StageRegData_out, w_sum[DATA_W-1:0]);
        w_alu_wr  = 1'b1;
      end
      OP_SUB: begin
        w_alu_acc = w_diff[DATA_W-1:0];
        w_alu_c   = w_diff[DATA_W];
        w_alu_v   = sub_ovf(ACCout, StageRegData_out, w_diff[DATA_W-1:0]);
        w_alu_wr  = 1'b1;
      end
      OP_AND: begin
        w_alu_acc = ACCout & StageRegData_out; w_alu_c = 1'b0; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_OR: begin
        w_alu_acc = ACCout | StageRegData_out; w_alu_c = 1'b0; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_XOR: begin
        w_alu_acc = ACCout ^ StageRegData_out; w_alu_c = 1'b0; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_NOT: begin
        w_alu_acc = ~ACCout; w_alu_c = 1'b0; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_SHL: begin
        w_alu_acc = ACCout << 1; w_alu_c = ACCout[DATA_W-1]; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_SHR: begin
        w_alu_acc = ACCout >> 1; w_alu_c = ACCout[0]; w_alu_v = 1'b0; w_alu_wr = 1'b1;
      end
      OP_JMP: begin w_br_op = 1'b1; w_br_cond = 1'b1;       end
      OP_JZ:  begin w_br_op = 1'b1; w_br_cond = zeroRegout; end
      OP_JC:  begin w_br_op = 1'b1; w_br_cond = coutRegout; end
      OP_RTI: w_is_rti = 1'b1;
`ifdef ACC_EXEC_MUL_EN
      5'd13:  w_is_mul = 1'b1;
`endif
      default: ;
    endcase
  end

  // Branch targets: absolute operand or PC-relative signed offset, both wrapping at 2^PC_W.
  assign w_pc_inc   = StageRegPCtr_out + 1'b1;
  assign w_off_sext = PC_W'(signed'(StageRegData_out));
  assign w_tgt_abs  = PC_W'(StageRegData_out);
  assign w_tgt_rel  = w_pc_inc + $unsigned(w_off_sext);

  always_comb begin
    w_pc_seq = w_pc_inc;
    if (w_is_rti) begin
      w_pc_seq = r_epc;
    end else if (w_br_op && w_br_cond) begin
      if (StageRegAddrMode_out == 3'd0)      w_pc_seq = w_tgt_abs;
      else if (StageRegAddrMode_out == 3'd1) w_pc_seq = w_tgt_rel;
    end
  end

`ifdef ACC_EXEC_MUL_EN
  localparam int PROD_W = 2 * DATA_W;
  localparam int CNT_W  = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t            r_state;
  state_t            w_state_nx;
  logic [CNT_W-1:0]  r_cnt;
  logic [PROD_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplier;
  logic [PROD_W-1:0] r_prod;
  logic [PC_W-1:0]   r_mul_npc;
  logic [PROD_W-1:0] w_prod_step;

  assign in_ready    = (r_state == S_IDLE);
  assign w_mul_done  = (r_state == S_MUL) && (r_cnt == CNT_LAST);
  assign w_prod_step = r_mplier[0] ? (r_prod + r_mcand) : r_prod;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      if (r_state == S_MUL) r_cnt <= r_cnt + 1'b1;
      else                  r_cnt <= '0;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && w_is_mul) w_state_nx = S_MUL;
      S_MUL:   if (r_cnt == CNT_LAST)    w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Shift-add datapath: one multiplier bit consumed per MUL cycle.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_mul) begin
      r_mcand   <= PROD_W'(ACCout);
      r_mplier  <= StageRegData_out;
      r_prod    <= '0;
      r_mul_npc <= w_pc_inc;
    end else if (r_state == S_MUL) begin
      r_prod   <= w_prod_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end
`else
  assign in_ready   = 1'b1;
  assign w_mul_done = 1'b0;
`endif

  always_comb begin
    w_cmp     = w_done;
    w_wr      = w_done & w_alu_wr;
    w_cmp_npc = w_pc_seq;
    w_res_acc = w_alu_acc;
    w_res_c   = w_alu_c;
    w_res_v   = w_alu_v;
`ifdef ACC_EXEC_MUL_EN
    if (w_mul_done) begin
      w_cmp     = 1'b1;
      w_wr      = 1'b1;
      w_cmp_npc = r_mul_npc;
      w_res_acc = w_prod_step[DATA_W-1:0];
      w_res_c   = |w_prod_step[PROD_W-1:DATA_W];
      w_res_v   = 1'b0;
    end
`endif
  end

  // A raw irq in the completing cycle counts as pending; RTI completion never vectors.
  assign w_take_irq = w_cmp & ~(w_done & w_is_rti) & (r_pend | irq) & r_ie;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ACCout         <= '0;
      coutRegout     <= 1'b0;
      zeroRegout     <= 1'b0;
      overflowRegout <= 1'b0;
      NextPctr       <= '0;
      StageComplete  <= 1'b0;
      r_epc          <= '0;
      r_ie           <= 1'b1;
      r_pend         <= 1'b0;
    end else begin
      StageComplete <= w_cmp;
      r_pend        <= w_take_irq ? 1'b0 : (r_pend | irq);
      if (w_cmp) begin
        NextPctr <= w_take_irq ? InteruptAdrReg : w_cmp_npc;
        if (w_take_irq) begin
          r_epc <= w_cmp_npc;
          r_ie  <= 1'b0;
        end else if (w_done && w_is_rti) begin
          r_ie <= 1'b1;
        end
      end
      if (w_wr) begin
        ACCout         <= w_res_acc;
        coutRegout     <= w_res_c;
        overflowRegout <= w_res_v;
        zeroRegout     <= (w_res_acc == '0);
      end
    end
  end

endmodule

// File: doc/acc_exec_stage.md
ACC_EXEC_STAGE -- requirements
Module: acc_exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 8, accumulator/operand width (legal 4..32).
REQ-002 SHALL have parameter PC_W, default 8, program-counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  stage register holds an instruction.
REQ-006 SHALL have port in_ready  output  1  block can accept an instruction this cycle.
REQ-007 SHALL have port StageRegInstr_out  input  5  opcode.
REQ-008 SHALL have port StageRegAddrMode_out  input  3  addressing mode (branches only).
REQ-009 SHALL have port StageRegData_out  input  DATA_W  operand/branch offset.
REQ-010 SHALL have port StageRegPCtr_out  input  PC_W  PC of the instruction.
REQ-011 SHALL have port irq  input  1  level interrupt request.
REQ-012 SHALL have port InteruptAdrReg  input  PC_W  interrupt vector.
REQ-013 SHALL have outputs ACCout (DATA_W), coutRegout, zeroRegout, overflowRegout (1 each), NextPctr (PC_W), StageComplete (1), all registered.

Function
REQ-014 Opcodes: 0 NOP, 1 LDA, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 SHL, 9 SHR, 10 JMP, 11 JZ, 12 JC, 13 MUL, 14 RTI; 15..31 SHALL execute as NOP.
REQ-015 FSM states IDLE, MUL, SHALL start in IDLE; in_ready = 1 only in IDLE.
REQ-016 Acceptance SHALL occur on an edge with in_valid & in_ready; non-MUL ops update outputs on that edge and assert StageComplete for exactly the following cycle.
REQ-017 ADD/SUB SHALL compute DATA_W+1-bit results; cout = carry-out (ADD) or borrow (SUB); overflow = signed two's-complement overflow.
REQ-018 AND/OR/XOR/NOT/LDA SHALL clear cout and overflow; SHL/SHR SHALL set cout to the bit shifted out, fill 0, clear overflow.
REQ-019 zeroRegout SHALL update on every ACC-writing op as (new ACC == 0); NOP/branches/RTI SHALL leave ACC and all flags unchanged.
REQ-020 NextPctr SHALL default to StageRegPCtr_out+1 (mod 2^PC_W); taken branch target = data (mode 0) or PC+1+sign-extended data (mode 1); modes 2..7 SHALL behave as NOP.
REQ-021 JZ/JC SHALL test the flag values held before the branch executes.
REQ-022 MUL SHALL enter MUL state, perform shift-add over exactly DATA_W cycles, then write ACC = low DATA_W product bits, cout = (high half != 0), overflow = 0, and pulse StageComplete; total latency DATA_W+1 cycles from acceptance.
REQ-023 irq SHALL be latched into a pending bit; when an instruction completes with pending = 1 and interrupt-enable IE = 1, NextPctr SHALL be InteruptAdrReg, saved-PC EPC SHALL take the would-be NextPctr, IE SHALL clear, pending SHALL clear.
REQ-024 RTI SHALL set NextPctr = EPC and IE = 1; an interrupt SHALL NOT be taken on the RTI completion itself.
REQ-025 irq asserted while in MUL state SHALL be held pending until the MUL completes.

Reset
REQ-026 reset SHALL asynchronously force IDLE, ACCout = 0, all flags = 0, NextPctr = 0, StageComplete = 0, EPC = 0, pending = 0, IE = 1; an in-flight MUL SHALL be discarded with no StageComplete.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-028 With ACC_EXEC_MUL_EN defined, MUL SHALL behave per REQ-022; without it, opcode 13 SHALL execute as a single-cycle NOP, no MUL state or multiplier logic SHALL exist, and in_ready SHALL be constant 1 outside reset.

Verification
REQ-029 LDA 0x7F then ADD 0x01 (DATA_W=8) -> ACC=0x80, cout=0, overflow=1, zero=0, StageComplete one cycle per op.
REQ-030 LDA 0x00, SUB 0x01 -> ACC=0xFF, cout=1, overflow=0; then JC mode 1 data 0xFE at PC 0x10 -> NextPctr=0x0F.
REQ-031 LDA 0x0D, MUL 0x0B (macro on) -> in_ready low 8 cycles, StageComplete 9 cycles after acceptance, ACC=0x8F, cout=0.
REQ-032 irq pulsed during ADD at PC 0x20, InteruptAdrReg=0x80 -> NextPctr=0x80; later RTI -> NextPctr=0x21, IE=1.
REQ-033 reset asserted mid-MUL -> outputs zero immediately, no StageComplete, next LDA 0x05 accepted and completes normally.
REQ-034 Opcode 13 with macro off -> ACC/flags unchanged, NextPctr=PC+1, StageComplete after one cycle.
